// File: rtl/rf_wr_arbiter_pkg.sv
// rf_ctrl_pkg: shared state type and helpers for the register-file write arbiter
package rf_ctrl_pkg;
    typedef enum logic {INIT, ARB} state_t;
    localparam int MAXW = 4096;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    // extracts field i of width w from a packed bus (caller widens/truncates)
    function automatic logic [MAXW-1:0] slice(input logic [MAXW-1:0] bus, input int i, input int w);
        return (bus >> (i * w)) & ({MAXW{1'b1}} >> (MAXW - w));
    endfunction
endpackage

// File: rtl/rf_wr_arbiter_if.sv
// rf_wr_arbiter_if: requester handshake and register-file write bus
interface rf_wr_arbiter_if import rf_ctrl_pkg::*; #(
    parameter int NBIT = 64,
    parameter int NADDR = 4,
    parameter int NREQ = 4
);
    logic                    CLEAR;
    logic [NREQ-1:0]         REQ_VALID;
    logic [NREQ-1:0]         REQ_READY;
    logic [NREQ*NADDR-1:0]   REQ_ADDR;
    logic [NREQ*NBIT-1:0]    REQ_DATA;
    logic                    ENABLE;
    logic                    WR;
    logic [NADDR-1:0]        ADD_WR;
    logic [NBIT-1:0]         DATAIN;
    logic [clog2(NREQ)-1:0]  GRANT_ID;
    logic                    INIT_DONE;
    logic                    ERR;
    modport slave (
        input  CLEAR, REQ_VALID, REQ_ADDR, REQ_DATA,
        output REQ_READY, ENABLE, WR, ADD_WR, DATAIN, GRANT_ID, INIT_DONE, ERR
    );
    modport master (
        output CLEAR, REQ_VALID, REQ_ADDR, REQ_DATA,
        input  REQ_READY, ENABLE, WR, ADD_WR, DATAIN, GRANT_ID, INIT_DONE, ERR
    );
endinterface

// File: rtl/rf_wr_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching upward from ptr_i
module rr_arbiter import rf_ctrl_pkg::*; #(
    parameter int NREQ = 4,
    localparam int IW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);
    int j;
    // scanning farthest-first lets the nearest valid requester overwrite the rest
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        j = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (en_i && valid_i[j]) begin
                gnt_o = '0;
                gnt_o[j] = 1'b1;
                idx_o = IW'(j);
            end
        end
    end
endmodule

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the register-file write port among requesters and
// runs a zero-fill sweep after reset or CLEAR
module rf_wr_arbiter import rf_ctrl_pkg::*; #(
    parameter int NBIT = 64,
    parameter int NREG = 16,
    parameter int NADDR = 4,
    parameter int NREQ = 4,
    localparam int IW = clog2(NREQ)
) (
    input logic CLK,
    input logic RESET,
    rf_wr_arbiter_if.slave bus
);
    state_t            state_q, state_d;
    logic [NADDR-1:0]  cnt_q, cnt_d, add_q, add_d, addr_sel;
    logic [IW-1:0]     ptr_q, ptr_d, gid_q, gid_d, idx;
    logic [NBIT-1:0]   dat_q, dat_d, data_sel;
    logic [NREQ-1:0]   gnt;
    logic              en_q, en_d, wr_q, wr_d, err_q, err_d, done_q, done_d, arb_en;

    assign arb_en = state_q == ARB && !bus.CLEAR;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .valid_i(bus.REQ_VALID),
        .ptr_i(ptr_q),
        .en_i(arb_en),
        .gnt_o(gnt),
        .idx_o(idx)
    );

    assign addr_sel = NADDR'(slice(MAXW'(bus.REQ_ADDR), int'(idx), NADDR));
    assign data_sel = NBIT'(slice(MAXW'(bus.REQ_DATA), int'(idx), NBIT));

    assign bus.REQ_READY = gnt;
    assign bus.ENABLE    = en_q;
    assign bus.WR        = wr_q;
    assign bus.ADD_WR    = add_q;
    assign bus.DATAIN    = dat_q;
    assign bus.GRANT_ID  = gid_q;
    assign bus.INIT_DONE = done_q;
    assign bus.ERR       = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        en_d    = 1'b1;
        wr_d    = 1'b0;
        add_d   = add_q;
        dat_d   = dat_q;
        gid_d   = gid_q;
        err_d   = 1'b0;
        done_d  = done_q;
        if (state_q == INIT) begin
            if (bus.CLEAR) begin
                cnt_d = '0;
            end else begin
                wr_d  = 1'b1;
                add_d = cnt_q;
                dat_d = '0;
                cnt_d = cnt_q + 1'b1;
                if (32'(cnt_q) == NREG - 1) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end
            end
        end else if (bus.CLEAR) begin
            state_d = INIT;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else begin
            done_d = 1'b1;
            if (|gnt) begin
                ptr_d = (32'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
                gid_d = idx;
                // out-of-range writes complete the handshake but never reach the RF
                if (32'(addr_sel) < NREG) begin
                    wr_d  = 1'b1;
                    add_d = addr_sel;
                    dat_d = data_sel;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ptr_q   <= '0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            add_q   <= '0;
            dat_q   <= '0;
            gid_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            add_q   <= add_d;
            dat_q   <= dat_d;
            gid_q   <= gid_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed checks of sweep, round-robin, ERR, CLEAR and RESET
`define CHK(t, o, e) chk(t, 64'(o), 64'(e))
module tb_rf_wr_arbiter;
    logic CLK = 1'b0;
    logic RESET;
    int n = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    rf_wr_arbiter_if #(.NBIT(64), .NADDR(4), .NREQ(4)) ia ();
    rf_wr_arbiter_if #(.NBIT(64), .NADDR(5), .NREQ(4)) ib ();

    rf_wr_arbiter #(.NBIT(64), .NREG(16), .NADDR(4), .NREQ(4)) u0 (.CLK(CLK), .RESET(RESET), .bus(ia));
    rf_wr_arbiter #(.NBIT(64), .NREG(20), .NADDR(5), .NREQ(4)) u1 (.CLK(CLK), .RESET(RESET), .bus(ib));

    always @(negedge CLK) begin
        if (RESET === 1'b0 && (ia.REQ_READY & (ia.REQ_READY - 1'b1)) != 4'b0000) begin
            fails++;
            $display("FAIL rdy_onehot observed=%0b", ia.REQ_READY);
            $error("check rdy_onehot");
        end
        if (RESET === 1'b0 && {ib.ERR, ib.WR} == 2'b11) begin
            fails++;
            $display("FAIL err_wr_excl");
            $error("check err_wr_excl");
        end
    end

    task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
        n++;
        assert (o === e) else begin
            fails++;
            $display("FAIL %s observed=%0h expected=%0h", t, o, e);
            $error("check %s", t);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    function automatic logic [63:0] d(input int i);
        return 64'hCAFE_0000 + 64'(i);
    endfunction

    initial begin
        RESET = 1'b1;
        ia.CLEAR = 1'b0;
        ia.REQ_VALID = '0;
        ia.REQ_ADDR = {4'd11, 4'd10, 4'd9, 4'd8};
        ia.REQ_DATA = {d(3), d(2), d(1), d(0)};
        ib.CLEAR = 1'b0;
        ib.REQ_VALID = '0;
        ib.REQ_ADDR = {5'd0, 5'd19, 5'd25, 5'd3};
        ib.REQ_DATA = {64'h0, 64'h19, 64'hDEAD, 64'h33};
        tick;
        tick;
        `CHK("rst_enable", ia.ENABLE, 0);
        `CHK("rst_wr", ia.WR, 0);
        `CHK("rst_addr", ia.ADD_WR, 0);
        `CHK("rst_data", ia.DATAIN, 0);
        `CHK("rst_gid", ia.GRANT_ID, 0);
        `CHK("rst_done", ia.INIT_DONE, 0);
        `CHK("rst_err", ia.ERR, 0);
        `CHK("rst_rdy", ia.REQ_READY, 0);
        RESET = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick;
            `CHK("init_wr", ia.WR, 1);
            `CHK("init_addr", ia.ADD_WR, c);
            `CHK("init_data", ia.DATAIN, 0);
            `CHK("init_rdy", ia.REQ_READY, 0);
            `CHK("init_done_lo", ia.INIT_DONE, 0);
        end
        tick;
        `CHK("sweep_done", ia.INIT_DONE, 1);
        `CHK("sweep_wr", ia.WR, 0);
        `CHK("arb_enable", ia.ENABLE, 1);

        ia.REQ_VALID = 4'b1111;
        #1;
        `CHK("rr_rdy0", ia.REQ_READY, 4'b0001);
        for (int k = 0; k < 8; k++) begin
            tick;
            `CHK("rr_wr", ia.WR, 1);
            `CHK("rr_gid", ia.GRANT_ID, k % 4);
            `CHK("rr_addr", ia.ADD_WR, 8 + k % 4);
            `CHK("rr_data", ia.DATAIN, d(k % 4));
            `CHK("rr_rdy", ia.REQ_READY, 4'b0001 << ((k + 1) % 4));
        end
        ia.REQ_VALID = '0;
        tick;
        `CHK("idle_wr", ia.WR, 0);

        ia.REQ_VALID = 4'b0010;
        #1;
        `CHK("single_rdy", ia.REQ_READY, 4'b0010);
        tick;
        `CHK("single_gid", ia.GRANT_ID, 1);
        ia.REQ_VALID = 4'b0011;
        #1;
        `CHK("ptr2_rdy", ia.REQ_READY, 4'b0001);
        tick;
        `CHK("ptr2_gid", ia.GRANT_ID, 0);
        `CHK("ptr2_addr", ia.ADD_WR, 8);
        ia.REQ_VALID = 4'b0100;
        tick;
        `CHK("to_ptr3_gid", ia.GRANT_ID, 2);
        `CHK("wrap_rdy", ia.REQ_READY, 4'b0100);
        tick;
        `CHK("wrap_gid", ia.GRANT_ID, 2);
        `CHK("wrap_wr", ia.WR, 1);

        ia.REQ_VALID = 4'b0001;
        ia.CLEAR = 1'b1;
        #1;
        `CHK("clr_rdy", ia.REQ_READY, 0);
        `CHK("clr_inflight_wr", ia.WR, 1);
        tick;
        ia.CLEAR = 1'b0;
        `CHK("clr_done_lo", ia.INIT_DONE, 0);
        `CHK("clr_wr", ia.WR, 0);
        for (int c = 0; c < 16; c++) begin
            tick;
            `CHK("clr_sweep_wr", ia.WR, 1);
            `CHK("clr_sweep_addr", ia.ADD_WR, c);
            `CHK("clr_sweep_data", ia.DATAIN, 0);
            `CHK("clr_sweep_rdy", ia.REQ_READY, (c == 15) ? 1 : 0);
        end
        tick;
        `CHK("post_clr_wr", ia.WR, 1);
        `CHK("post_clr_gid", ia.GRANT_ID, 0);
        `CHK("post_clr_addr", ia.ADD_WR, 8);
        `CHK("post_clr_done", ia.INIT_DONE, 1);
        ia.REQ_VALID = '0;

        `CHK("u1_done", ib.INIT_DONE, 1);
        ib.REQ_VALID = 4'b0010;
        #1;
        `CHK("err_rdy", ib.REQ_READY, 4'b0010);
        tick;
        ib.REQ_VALID = '0;
        `CHK("err_wr", ib.WR, 0);
        `CHK("err_pulse", ib.ERR, 1);
        tick;
        `CHK("err_clear", ib.ERR, 0);
        ib.REQ_VALID = 4'b0011;
        #1;
        `CHK("err_ptr2_rdy", ib.REQ_READY, 4'b0001);
        tick;
        `CHK("err_next_wr", ib.WR, 1);
        `CHK("err_next_addr", ib.ADD_WR, 3);
        `CHK("err_next_gid", ib.GRANT_ID, 0);
        ib.REQ_VALID = 4'b0100;
        tick;
        ib.REQ_VALID = '0;
        `CHK("lastreg_wr", ib.WR, 1);
        `CHK("lastreg_addr", ib.ADD_WR, 19);
        `CHK("lastreg_err", ib.ERR, 0);

        ia.CLEAR = 1'b1;
        tick;
        ia.CLEAR = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tick;
            `CHK("pre_rst_addr", ia.ADD_WR, c);
        end
        RESET = 1'b1;
        tick;
        RESET = 1'b0;
        `CHK("midrst_wr", ia.WR, 0);
        `CHK("midrst_enable", ia.ENABLE, 0);
        `CHK("midrst_addr", ia.ADD_WR, 0);
        `CHK("midrst_done", ia.INIT_DONE, 0);
        for (int c = 0; c < 16; c++) begin
            tick;
            `CHK("resweep_wr", ia.WR, 1);
            `CHK("resweep_addr", ia.ADD_WR, c);
        end
        tick;
        `CHK("resweep_done", ia.INIT_DONE, 1);
        `CHK("resweep_idle", ia.WR, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
